memory_responder: RTL and testbench

// - Memory-side end of the core's memory interface: answers the core's address/data/write-enable requests with read data.
// - Holds a word-addressed RAM cleared after reset, then filled by a streaming program loader, then serves the core.
// - Owns the core_hold stall so the pipeline waits until memory holds a program.

---
 rtl/core_mem_pkg.sv | 24 ++
 rtl/memory_responder_if.sv | 32 +++
 rtl/sp_ram.sv | 27 ++
 rtl/memory_responder.sv | 148 ++++++++++++++
 tb/tb_memory_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the memory responder and its interface.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package core_mem_pkg;

    localparam int          WORD_W           = 16;
    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;
    localparam logic [15:0] MMIO_ADDR        = 16'hFFFF;

    // Responder lifecycle: clear RAM, accept the program image, serve the core.
    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Source of the word presented on data_from_memory in the next cycle.
    typedef enum logic [1:0] {
        RSEL_NOP  = 2'd0,
        RSEL_RAM  = 2'd1,
        RSEL_MMIO = 2'd2
    } rd_sel_t;

endpackage

// File: rtl/memory_responder_if.sv
// Bundles the core request/response, program loader and MMIO signals.
// Latency: none (wiring only).
// Backpressure: load_valid/load_ready handshake on the loader; the core has none.
interface memory_responder_if #(
    parameter int ADDR_BITS = 10
);
    logic [core_mem_pkg::WORD_W-1:0] address_to_memory;
    logic [core_mem_pkg::WORD_W-1:0] data_to_memory;
    logic                            data_to_memory_write_en;
    logic [core_mem_pkg::WORD_W-1:0] data_from_memory;
    logic                            core_hold;
    logic                            load_valid;
    logic                            load_ready;
    logic [core_mem_pkg::WORD_W-1:0] load_data;
    logic                            load_last;
    logic [ADDR_BITS:0]              load_count;
    logic [core_mem_pkg::WORD_W-1:0] io_out;

    // Core plus loader side: drives requests and image words.
    modport master (
        output address_to_memory, data_to_memory, data_to_memory_write_en,
        output load_valid, load_data, load_last,
        input  data_from_memory, core_hold, load_ready, load_count, io_out
    );

    // Responder side.
    modport slave (
        input  address_to_memory, data_to_memory, data_to_memory_write_en,
        input  load_valid, load_data, load_last,
        output data_from_memory, core_hold, load_ready, load_count, io_out
    );
endinterface

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, write-first, one registered read port.
// Latency: 1 cycle from address to rdata; a write returns wdata on rdata.
// Backpressure: none, accepts a read or write every cycle.
module sp_ram #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_W    = 16
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write-first port: a store forwards its own data to the read register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/memory_responder.sv
// Memory end of the core bus: clears RAM, loads a program image, then serves core reads/stores.
// Latency: read data 1 cycle after the address (write-first); NOP_WORD while not running.
// Backpressure: loader throttled by load_ready (LOAD only); core stalled by core_hold until RUN.
// Optional MMIO output register at 16'hFFFF when MEMORY_RESPONDER_MMIO_EN is defined.
module memory_responder
    import core_mem_pkg::*;
#(
    parameter int                ADDR_BITS = 10,
    parameter logic [WORD_W-1:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    memory_responder_if.slave bus
);
    localparam int                 DEPTH      = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS:0] COUNT_FULL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] COUNT_LAST = (ADDR_BITS + 1)'(DEPTH - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_BITS-1:0]   clear_ptr_q;
    logic [ADDR_BITS:0]     load_count_q;
    logic                   core_hold_q;
    logic                   load_ready_q;
    rd_sel_t                rd_sel_q;
    logic [WORD_W-1:0]      io_out_q;
    logic                   mmio_hit;
    logic                   beat;

    logic [ADDR_BITS-1:0]   ram_addr;
    logic                   ram_we;
    logic [WORD_W-1:0]      ram_wdata;
    logic [WORD_W-1:0]      ram_rdata;

`ifdef MEMORY_RESPONDER_MMIO_EN
    // Full 16-bit compare so only FFFF reaches the register, never an alias.
    assign mmio_hit = (state_q == RUN) && (bus.address_to_memory == MMIO_ADDR);

    // MMIO output register: written by core stores to FFFF while running.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            io_out_q <= '0;
        end else if (mmio_hit && bus.data_to_memory_write_en) begin
            io_out_q <= bus.data_to_memory;
        end
    end
`else
    // Without MMIO the upper address bits are simply ignored (aliasing wrap).
    logic [WORD_W-ADDR_BITS-1:0] unused_addr_bits;
    assign unused_addr_bits = bus.address_to_memory[WORD_W-1:ADDR_BITS];
    assign mmio_hit         = 1'b0;
    assign io_out_q         = '0;
`endif

    // Next state and RAM port steering: clear pointer, loader slot or core request.
    always_comb begin
        state_d   = state_q;
        beat      = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state_q)
            INIT: begin
                ram_addr = clear_ptr_q;
                ram_we   = 1'b1;
                if (clear_ptr_q == LAST_IDX) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                beat      = bus.load_valid && load_ready_q;
                ram_addr  = load_count_q[ADDR_BITS-1:0];
                ram_we    = beat;
                ram_wdata = bus.load_data;
                // Stop on the image's last word, or when the RAM is full rather than wrap.
                if (beat && (bus.load_last || load_count_q == COUNT_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_addr  = bus.address_to_memory[ADDR_BITS-1:0];
                ram_we    = bus.data_to_memory_write_en && !mmio_hit;
                ram_wdata = bus.data_to_memory;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State, counters and registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= INIT;
            clear_ptr_q  <= '0;
            load_count_q <= '0;
            core_hold_q  <= 1'b1;
            load_ready_q <= 1'b0;
            rd_sel_q     <= RSEL_NOP;
        end else begin
            state_q      <= state_d;
            core_hold_q  <= (state_d != RUN);
            load_ready_q <= (state_d == LOAD);
            if (state_q == INIT) begin
                clear_ptr_q <= clear_ptr_q + 1'b1;
            end
            if (beat && load_count_q != COUNT_FULL) begin
                load_count_q <= load_count_q + 1'b1;
            end
            // Only a request made while running produces real data next cycle.
            if (state_q != RUN) begin
                rd_sel_q <= RSEL_NOP;
            end else if (mmio_hit) begin
                rd_sel_q <= RSEL_MMIO;
            end else begin
                rd_sel_q <= RSEL_RAM;
            end
        end
    end

    sp_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (WORD_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Read-data source select; every input of this mux is a register.
    always_comb begin
        bus.data_from_memory = NOP_WORD;
        case (rd_sel_q)
            RSEL_RAM:  bus.data_from_memory = ram_rdata;
            RSEL_MMIO: bus.data_from_memory = io_out_q;
            default:   bus.data_from_memory = NOP_WORD;
        endcase
    end

    assign bus.core_hold  = core_hold_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_count = load_count_q;
    assign bus.io_out     = io_out_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder (ADDR_BITS=4) against a behavioural memory model.
// Latency: checks read data one cycle after each request.
// Backpressure: loader valid is randomly gapped; core traffic is unthrottled.
module tb_memory_responder;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
`ifdef MEMORY_RESPONDER_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    memory_responder_if #(.ADDR_BITS(AB)) bus ();

    memory_responder #(
        .ADDR_BITS (AB),
        .NOP_WORD  (16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain array of words, the MMIO word and the accepted-word count.
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref_io;
    int          ref_count;
    logic [15:0] load_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_core();
        bus.address_to_memory       = 16'($urandom);
        bus.data_to_memory          = 16'($urandom);
        bus.data_to_memory_write_en = 1'($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        ref_io    = 16'h0000;
        ref_count = 0;
    endtask

    task automatic apply_reset(input int cycles);
        int n;
        int bad;
        reset_n        = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = 16'h0000;
        rand_core();
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_hold",  bus.core_hold, 1);
        check("rst_ready", bus.load_ready, 0);
        check("rst_data",  bus.data_from_memory, 16'h0000);
        check("rst_count", bus.load_count, 0);
        check("rst_io",    bus.io_out, 16'h0000);
        model_reset();
        reset_n = 1'b1;
        n   = 0;
        bad = 0;
        while (bus.load_ready !== 1'b1 && n < 100) begin
            rand_core();
            @(posedge clk);
            #1;
            n++;
            if (bus.core_hold !== 1'b1 || bus.data_from_memory !== 16'h0000) bad++;
        end
        check("init_cycles",   n, DEPTH);
        check("init_hold_nop", bad, 0);
    endtask

    // Streams load_q[0..n-1] with gapped valid; the image ends on the last word or when RAM is full.
    task automatic load(input int n, input bit use_last);
        int  idx;
        int  cyc;
        int  bad;
        bit  v;
        bit  rdy;
        idx = 0;
        cyc = 0;
        bad = 0;
        while (idx < n && cyc < 500) begin
            v   = ($urandom_range(0, 2) != 0);
            rdy = bus.load_ready;
            bus.load_valid = v;
            bus.load_data  = load_q[idx];
            bus.load_last  = use_last && (idx == n - 1);
            rand_core();
            @(posedge clk);
            #1;
            cyc++;
            if (v && rdy) begin
                if (ref_count < DEPTH) ref_mem[ref_count] = load_q[idx];
                ref_count++;
                idx++;
            end
            if (idx < n && (bus.core_hold !== 1'b1 || bus.load_ready !== 1'b1)) bad++;
            if (bus.data_from_memory !== 16'h0000) bad++;
        end
        bus.load_valid              = 1'b0;
        bus.load_last               = 1'b0;
        bus.data_to_memory_write_en = 1'b0;
        check("load_words_taken", idx, n);
        check("load_handshake",   bad, 0);
        check("load_hold_fell",   bus.core_hold, 0);
        check("load_ready_off",   bus.load_ready, 0);
        check("load_count",       bus.load_count, ref_count);
    endtask

    // One core request; expected data derives from the model state before/after the store.
    task automatic run_cycle(input logic [15:0] addr, input logic [15:0] wd, input bit we);
        logic [15:0] exp;
        logic [3:0]  idx;
        bit          hit;
        idx = addr[3:0];
        hit = MMIO && (addr == 16'hFFFF);
        bus.address_to_memory       = addr;
        bus.data_to_memory          = wd;
        bus.data_to_memory_write_en = we;
        if (we) begin
            if (hit) ref_io = wd;
            else     ref_mem[idx] = wd;
            exp = wd;
        end else begin
            exp = hit ? ref_io : ref_mem[idx];
        end
        @(posedge clk);
        #1;
        bus.data_to_memory_write_en = 1'b0;
        check("run_rdata", bus.data_from_memory, exp);
        check("run_io",    bus.io_out, ref_io);
    endtask

    task automatic random_traffic(input int cycles);
        logic [15:0] a;
        for (int i = 0; i < cycles; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            run_cycle(a, 16'($urandom), 1'($urandom));
        end
        check("run_hold_low", bus.core_hold, 0);
    endtask

    initial begin
        bus.load_valid              = 1'b0;
        bus.load_data               = 16'h0000;
        bus.load_last               = 1'b0;
        bus.address_to_memory       = 16'h0000;
        bus.data_to_memory          = 16'h0000;
        bus.data_to_memory_write_en = 1'b0;

        // Short image with a gapped loader.
        apply_reset(3);
        load_q = '{16'h00A1, 16'h00B2, 16'h00C3};
        load(3, 1'b1);
        run_cycle(16'h0000, 16'h0000, 1'b0);
        check("dir_ram0", bus.data_from_memory, 16'h00A1);
        run_cycle(16'h0011, 16'h0000, 1'b0);
        check("dir_alias_b2", bus.data_from_memory, 16'h00B2);
        run_cycle(16'h0002, 16'h0000, 1'b0);
        check("dir_ram2", bus.data_from_memory, 16'h00C3);
        run_cycle(16'h0005, 16'h1234, 1'b1);
        check("dir_write_first", bus.data_from_memory, 16'h1234);
        run_cycle(16'hFFFF, 16'hBEEF, 1'b1);
        check("dir_ffff_wf", bus.data_from_memory, 16'hBEEF);
        check("dir_io_out", bus.io_out, MMIO ? 16'hBEEF : 16'h0000);
        run_cycle(16'h000F, 16'h0000, 1'b0);
        check("dir_ram15", bus.data_from_memory, MMIO ? 16'h0000 : 16'hBEEF);
        run_cycle(16'hFFFF, 16'h0000, 1'b0);
        check("dir_read_ffff", bus.data_from_memory, 16'hBEEF);
        run_cycle(16'h0005, 16'h0000, 1'b0);
        check("dir_ram5", bus.data_from_memory, 16'h1234);
        random_traffic(150);

        // Reset in the middle of RUN: RAM and io_out must be cleared again.
        run_cycle(16'h0005, 16'h7777, 1'b1);
        run_cycle(16'hFFFF, 16'h5555, 1'b1);
        apply_reset(1);
        load_q = '{16'h5A5A};
        load(1, 1'b1);
        run_cycle(16'h0005, 16'h0000, 1'b0);
        check("rerun_ram5_clear", bus.data_from_memory, 16'h0000);
        check("rerun_io_clear", bus.io_out, 16'h0000);
        random_traffic(100);

        // Full image with no last marker: RAM fills, the extra word is refused.
        apply_reset(2);
        load_q.delete();
        for (int i = 0; i < DEPTH; i++) load_q.push_back(16'($urandom));
        load(DEPTH, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        check("full_count", bus.load_count, DEPTH);
        check("full_ready_off", bus.load_ready, 0);
        run_cycle(16'h0000, 16'h0000, 1'b0);
        check("full_no_wrap", bus.data_from_memory, load_q[0]);
        random_traffic(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
